// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
// The master side is the pipeline plus data memory, the slave side is the LSU.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_is_store;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;

    logic                  resp_valid;
    logic                  resp_err;
    logic [31:0]           resp_rdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_re;
    logic                  mem_we;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  mem_addr, mem_re, mem_we, mem_wdata
    );

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store front end: RV32I alignment checks, load extension,
// and sub-word stores done as read-modify-write on a word-only data memory.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter bit WORD_ADDR  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    load_store_unit_if.slave bus
);
    // state     | meaning
    // IDLE      | ready for a request, no memory access
    // LOAD      | read word, format and register the load result
    // STORE     | full-word write
    // RMW_READ  | read old word for a byte/halfword store
    // RMW_WRITE | write old word merged with the new lane
    // ERR       | misaligned or illegal request, no memory access
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        STORE     = 3'd2,
        RMW_READ  = 3'd3,
        RMW_WRITE = 3'd4,
        ERR       = 3'd5
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t                state;
    state_t                state_nxt;

    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           old_q;

    logic                  accept;
    logic                  req_bad;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic [31:0]           load_fmt;
    logic [31:0]           merged;
    logic [ADDR_WIDTH-1:0] mem_addr_lat;

    logic                  req_ready_c;
    logic                  mem_re_c;
    logic                  mem_we_c;
    logic [31:0]           mem_wdata_c;
    logic [ADDR_WIDTH-1:0] mem_addr_c;

    logic                  resp_valid_q;
    logic                  resp_err_q;
    logic [31:0]           resp_rdata_q;

    assign accept = bus.req_valid && req_ready_c;

    // Stores only exist as B/H/W; the unsigned encodings are load-only.
    always_comb begin
        req_bad = 1'b0;
        case (bus.req_funct3)
            F3_B, F3_BU: req_bad = bus.req_is_store && bus.req_funct3[2];
            F3_H, F3_HU: req_bad = bus.req_addr[0] || (bus.req_is_store && bus.req_funct3[2]);
            F3_W:        req_bad = (bus.req_addr[1:0] != 2'b00);
            default:     req_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_bad) begin
                        state_nxt = ERR;
                    end else if (!bus.req_is_store) begin
                        state_nxt = LOAD;
                    end else if (bus.req_funct3 == F3_W) begin
                        state_nxt = STORE;
                    end else begin
                        state_nxt = RMW_READ;
                    end
                end
            end
            RMW_READ:                   state_nxt = RMW_WRITE;
            LOAD, STORE, RMW_WRITE, ERR: state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            old_q    <= '0;
        end else begin
            if (accept) begin
                funct3_q <= bus.req_funct3;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
            end
            if (state == RMW_READ) begin
                old_q <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        lane_b = bus.mem_rdata[7:0];
        case (addr_q[1:0])
            2'd0: lane_b = bus.mem_rdata[7:0];
            2'd1: lane_b = bus.mem_rdata[15:8];
            2'd2: lane_b = bus.mem_rdata[23:16];
            2'd3: lane_b = bus.mem_rdata[31:24];
            default: lane_b = bus.mem_rdata[7:0];
        endcase
        lane_h = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

        load_fmt = bus.mem_rdata;
        case (funct3_q)
            F3_B:    load_fmt = {{24{lane_b[7]}}, lane_b};
            F3_H:    load_fmt = {{16{lane_h[15]}}, lane_h};
            F3_BU:   load_fmt = {24'h000000, lane_b};
            F3_HU:   load_fmt = {16'h0000, lane_h};
            default: load_fmt = bus.mem_rdata;
        endcase
    end

    // Only SB (funct3[0]=0) and SH (funct3[0]=1) reach the merge path.
    always_comb begin
        merged = old_q;
        if (funct3_q[0]) begin
            if (addr_q[1]) begin
                merged[31:16] = wdata_q[15:0];
            end else begin
                merged[15:0] = wdata_q[15:0];
            end
        end else begin
            case (addr_q[1:0])
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: merged = old_q;
            endcase
        end
    end

    assign mem_addr_lat = WORD_ADDR ? {2'b00, addr_q[ADDR_WIDTH-1:2]}
                                    : {addr_q[ADDR_WIDTH-1:2], 2'b00};

    always_comb begin
        req_ready_c = 1'b0;
        mem_re_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_wdata_c = '0;
        mem_addr_c  = mem_addr_lat;
        case (state)
            IDLE: begin
                req_ready_c = 1'b1;
                mem_addr_c  = '0;
            end
            LOAD, RMW_READ: mem_re_c = 1'b1;
            STORE: begin
                mem_we_c    = 1'b1;
                mem_wdata_c = wdata_q;
            end
            RMW_WRITE: begin
                mem_we_c    = 1'b1;
                mem_wdata_c = merged;
            end
            default: ;
        endcase
    end

    // The response lands in the cycle after the final state, when the FSM is
    // already back in IDLE and can accept the next request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= (state == LOAD) || (state == STORE) ||
                            (state == RMW_WRITE) || (state == ERR);
            resp_err_q   <= (state == ERR);
            resp_rdata_q <= (state == LOAD) ? load_fmt : 32'h0;
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.mem_re     = mem_re_c;
    assign bus.mem_we     = mem_we_c;
    assign bus.mem_wdata  = mem_wdata_c;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage front end sitting between the EX/MEM pipeline register and the data memory.
- Accepts one load or store request at a time and enforces RV32I natural alignment.
- Loads: selects the byte, halfword or word and sign- or zero-extends it.
- Sub-word stores: done as read-modify-write, because the data memory writes only whole 32-bit words.
- Stalls the pipeline through a ready/valid handshake.

Parameters:
- ADDR_WIDTH, 32, width of the byte address from the pipeline.
- WORD_ADDR, 1:
  - 1: mem_addr is the word index, {2'b00, addr[31:2]}.
  - 0: mem_addr is the byte address with bits [1:0] forced to 0.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present from pipeline.
- req_ready  output  1  unit idle and able to accept; pipeline stalls while low.
- req_is_store  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  32  store data; low byte or halfword used for SB/SH.
- resp_valid  output  1  one-cycle completion pulse.
- resp_err  output  1  valid with resp_valid: misaligned or illegal funct3.
- resp_rdata  output  32  extended load result; 0 for stores and errors.
- mem_addr  output  ADDR_WIDTH  address to data memory.
- mem_re  output  1  data memory read enable.
- mem_we  output  1  data memory write enable.
- mem_wdata  output  32  word written to data memory.
- mem_rdata  input  32  combinational read data from data memory.

Behaviour:
- Reset (rst high, async):
  - FSM goes to IDLE.
  - req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_re=0, mem_we=0, mem_wdata=0, mem_addr=0.
  - An in-flight operation is abandoned. No mem_we is issued for it after reset.
- Handshake:
  - A request is accepted on a rising edge with req_valid && req_ready.
  - At acceptance, op, funct3, addr and wdata are latched.
  - req_ready is high only in IDLE.
- FSM states: IDLE, LOAD, STORE, RMW_READ, RMW_WRITE, ERR.
- IDLE, on accept:
  - Error case → ERR when any of these holds:
    - misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0;
    - illegal funct3: 011, 110, 111, or any store with funct3[2]=1.
  - Otherwise load → LOAD; SW → STORE; SB/SH → RMW_READ.
- LOAD:
  - Drive mem_re=1 and mem_addr.
  - On the edge, latch the formatted mem_rdata into resp_rdata. Go to IDLE.
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend bit 7/15 of the selected lane. LBU/LHU zero-extend.
- STORE:
  - Drive mem_we=1 and mem_wdata=req_wdata. Go to IDLE.
- RMW_READ:
  - Drive mem_re=1. Latch mem_rdata as the old word. Go to RMW_WRITE.
- RMW_WRITE:
  - Drive mem_we=1 and mem_wdata = old word with the selected lane replaced by wdata[7:0] or wdata[15:0].
  - All other bytes are unchanged. Go to IDLE.
- ERR:
  - No memory access (mem_re=mem_we=0). Go to IDLE with resp_err=1.
- Completion response:
  - resp_valid, resp_err and resp_rdata are registered.
  - resp_valid pulses high for exactly the one cycle after the final state, while the FSM is already back in IDLE.
  - A new request may be accepted in that same cycle.
- Latency from the accept edge to the resp_valid cycle:
  - load, SW and error: 2 cycles;
  - SB/SH: 3 cycles.
- mem_re and mem_we:
  - Never both high at the same time.
  - Both are 0 in IDLE.
  - mem_addr holds the latched address in every non-IDLE state.
- req_valid while busy is ignored; the pipeline must hold the request.

Test Plan:
1. mem[0x40>>2]=0x8899AABB; LB at addr 0x41 → mem_re 1 cycle; resp_rdata=0xFFFFFFAA, resp_err=0, 2-cycle latency.
2. Same word; LHU at 0x42 → resp_rdata=0x00008899. LW at 0x40 → 0x8899AABB.
3. SB wdata=0x000000CC to 0x43 with old word 0x8899AABB:
   - cycle-by-cycle: RMW_READ(re=1), then RMW_WRITE(we=1, wdata=0xCC99AABB), then resp_valid;
   - a following LW at 0x40 returns 0xCC99AABB.
4. SH to 0x01 and LW to 0x42 → resp_err=1, resp_rdata=0, mem_we and mem_re never asserted.
5. Back-to-back: SW 0x12345678 to 0x10 accepted in the resp_valid cycle of the prior load:
   - req_ready high in that cycle; mem_we next cycle with mem_addr=0x4 (WORD_ADDR=1).
6. Assert rst during RMW_READ of an SB → mem_we stays 0, all outputs 0 immediately, req_ready=1; memory word unchanged.
